// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the LCD text sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StInitIssue,
    StInitWait,
    StIdle,
    StWait
  } lcd_state_e;

  localparam logic [7:0] FUNC_SET_8BIT_2LINE = 8'h38;
  localparam logic [7:0] DISP_ON_CUR_OFF     = 8'h0C;
  localparam logic [7:0] CLEAR               = 8'h01;
  localparam logic [7:0] ENTRY_INC           = 8'h06;

  localparam int unsigned INIT_LEN = 5;

  // Function set is sent twice so the panel latches 8-bit mode reliably.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0, 3'd1: cmd = FUNC_SET_8BIT_2LINE;
      3'd2:       cmd = DISP_ON_CUR_OFF;
      3'd3:       cmd = CLEAR;
      default:    cmd = ENTRY_INC;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_text_sequencer_if.sv
// Start/done handshake toward the LCD custom-instruction controller.
interface lcd_text_sequencer_if;
  logic        lcd_start;
  logic [31:0] lcd_dataa;
  logic [31:0] lcd_datab;
  logic        lcd_done;

  modport master (output lcd_start, output lcd_dataa, output lcd_datab, input lcd_done);
  modport slave  (input lcd_start, input lcd_dataa, input lcd_datab, output lcd_done);
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO of {rs, byte} entries with registered full/empty and sticky overflow.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full_q, empty_q, overflow_q;
  logic             push_ok, pop_ok;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;
  assign cnt_d   = cnt_q + CntW'(push_ok) - CntW'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CntW'(DEPTH));
      empty_q <= (cnt_d == '0);
      if (push && full_q) overflow_q <= 1'b1;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/lcd_text_sequencer.sv
// Runs the HD44780 power-up init, then drains queued command/character bytes
// to the LCD controller one start/done handshake at a time.
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PWRUP_CYCLES = 750000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_rs,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  init_done,
  output logic                  busy,
  lcd_text_sequencer_if.master  lcd
);

  localparam int unsigned CntW = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;

  lcd_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            init_done_q, init_done_d;
  logic [8:0]      ent_q, ent_d;
  logic [8:0]      cur, head;
  logic            start, pop, fifo_empty;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data ({wr_rs, wr_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StPwrup;
      cnt_q       <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      ent_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      ent_q       <= ent_d;
    end
  end

  // Start is decoded from state so it can never still be high once WAIT is entered;
  // the issued entry is latched so data holds steady until done.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    ent_d       = ent_q;
    cur         = ent_q;
    start       = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StPwrup: begin
        if (cnt_q == CntW'(PWRUP_CYCLES - 1)) begin
          state_d = StInitIssue;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StInitIssue: begin
        start   = 1'b1;
        cur     = {1'b0, init_cmd(idx_q)};
        ent_d   = cur;
        state_d = StInitWait;
      end
      StInitWait: begin
        if (lcd.lcd_done) begin
          if (idx_q == 3'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StInitIssue;
          end
        end
      end
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          start   = 1'b1;
          cur     = head;
          ent_d   = head;
          state_d = StWait;
        end
      end
      StWait: begin
        if (lcd.lcd_done) state_d = StIdle;
      end
      default: state_d = StPwrup;
    endcase
  end

  assign lcd.lcd_start = start;
  assign lcd.lcd_dataa = {31'b0, cur[8]};
  assign lcd.lcd_datab = {24'b0, cur[7:0]};
  assign empty         = fifo_empty;
  assign init_done     = init_done_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed bench with a controller model and an in-order scoreboard of expected writes.
module tb_lcd_text_sequencer;
  import lcd_pkg::*;

  localparam int unsigned Depth = 16;
  localparam int unsigned Pwrup = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_rs;
  logic [7:0] wr_data;
  logic       full, empty, overflow, init_done, busy;

  lcd_text_sequencer_if lcd ();

  lcd_text_sequencer #(
    .FIFO_DEPTH   (Depth),
    .PWRUP_CYCLES (Pwrup)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_rs     (wr_rs),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .init_done (init_done),
    .busy      (busy),
    .lcd       (lcd)
  );

  always #5 clk = ~clk;

  logic [8:0] sb[$];
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int pulse_cnt = 0;
  int done_cnt = 0;
  bit hold_done = 1'b0;
  bit rand_lat = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_init_rom();
    sb.delete();
    sb.push_back({1'b0, FUNC_SET_8BIT_2LINE});
    sb.push_back({1'b0, FUNC_SET_8BIT_2LINE});
    sb.push_back({1'b0, DISP_ON_CUR_OFF});
    sb.push_back({1'b0, CLEAR});
    sb.push_back({1'b0, ENTRY_INC});
  endtask

  // Called at the negedge where a start pulse is seen; returns right after raising done.
  task automatic serve_pulse();
    logic [8:0]  exp;
    logic [31:0] a0, b0;
    int          lat, k;
    bit          fin;
    pulse_cnt++;
    a0 = lcd.lcd_dataa;
    b0 = lcd.lcd_datab;
    check("start_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check("dataa", a0, {31'b0, exp[8]});
      check("datab", b0, {24'b0, exp[7:0]});
    end
    lat = rand_lat ? int'($urandom_range(50, 1)) : 1;
    k   = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (reset) begin
        fin = 1'b1;
      end else begin
        check("start_low_in_wait", 32'(lcd.lcd_start), 32'd0);
        check("dataa_stable", lcd.lcd_dataa, a0);
        check("datab_stable", lcd.lcd_datab, b0);
        k++;
        if (!hold_done && k >= lat) begin
          lcd.lcd_done = 1'b1;
          done_cnt++;
          fin = 1'b1;
        end
      end
    end
  endtask

  initial begin : ctrl_model
    lcd.lcd_done = 1'b0;
    forever begin
      @(negedge clk);
      lcd.lcd_done = 1'b0;
      if (!reset && lcd.lcd_start) serve_pulse();
    end
  end

  task automatic push(input logic rs, input logic [7:0] d, input bit expect_accept);
    wr_en   = 1'b1;
    wr_rs   = rs;
    wr_data = d;
    if (expect_accept) sb.push_back({rs, d});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_start", 32'(lcd.lcd_start), 32'd0);
    check("rst_dataa", lcd.lcd_dataa, 32'd0);
    check("rst_datab", lcd.lcd_datab, 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
  endtask

  // Entered at the negedge where reset is released; start must rise on the Pwrup-th cycle.
  task automatic check_pwrup_delay(input bit with_text);
    for (int i = 1; i <= int'(Pwrup); i++) begin
      @(negedge clk);
      check("pwrup_start", 32'(lcd.lcd_start), 32'(i == int'(Pwrup)));
      check("pwrup_busy", 32'(busy), 32'd1);
      if (with_text && i == 7) check("empty_during_init", 32'(empty), 32'd0);
      wr_en   = with_text && (i == 5 || i == 6);
      wr_rs   = 1'b1;
      wr_data = (i == 5) ? 8'h48 : 8'h69;
      if (wr_en) sb.push_back({wr_rs, wr_data});
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_init();
    int g = 0;
    while (!init_done && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("init_done_rise", 32'(init_done), 32'd1);
    check("dones_at_init_done", done_cnt, 32'd5);
  endtask

  task automatic wait_pulses(input int n);
    int g = 0;
    while (pulse_cnt < n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("pulse_wait", 32'(pulse_cnt >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!(sb.size() == 0 && !busy && empty) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(g < 5000), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int pushed, g;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    load_init_rom();
    repeat (3) @(negedge clk);
    check_reset_values();

    // Power-up, init sequence, and text queued during PWRUP.
    reset = 1'b0;
    check_pwrup_delay(1'b1);
    wait_init();
    wait_pulses(7);
    @(negedge clk);
    check("empty_after_text", 32'(empty), 32'd1);
    wait_idle();
    check("idle_busy", 32'(busy), 32'd0);

    // Overflow with done withheld; 0xEE must be dropped.
    hold_done = 1'b1;
    push(1'b1, 8'h41, 1'b1);
    wait_pulses(8);
    for (int n = 0; n < int'(Depth); n++) begin
      push(n[0], 8'h50 + 8'(n), 1'b1);
      if (n == int'(Depth) - 2) check("not_full_15", 32'(full), 32'd0);
    end
    check("full_16", 32'(full), 32'd1);
    check("no_overflow_yet", 32'(overflow), 32'd0);
    push(1'b1, 8'hEE, 1'b0);
    check("overflow_set", 32'(overflow), 32'd1);
    check("still_full", 32'(full), 32'd1);
    hold_done = 1'b0;
    wait_pulses(8 + int'(Depth));
    wait_idle();
    check("overflow_sticky", 32'(overflow), 32'd1);
    check("empty_after_drain", 32'(empty), 32'd1);

    // Reset while in WAIT with three entries queued.
    hold_done = 1'b1;
    for (int n = 0; n < 4; n++) push(1'b1, 8'h30 + 8'(n), 1'b1);
    wait_pulses(9 + int'(Depth));
    @(posedge clk);
    #1;
    reset     = 1'b1;
    sb.delete();
    hold_done = 1'b0;
    done_cnt  = 0;
    pulse_cnt = 0;
    @(negedge clk);
    check_reset_values();
    load_init_rom();
    @(negedge clk);
    reset = 1'b0;
    check_pwrup_delay(1'b0);
    wait_init();

    // Wrap-around with random controller latency.
    rand_lat = 1'b1;
    pushed   = 0;
    g        = 0;
    while (pushed < 40 && g < 5000) begin
      if (!full) begin
        push(1'(pushed % 2), 8'($urandom), 1'b1);
        pushed++;
      end else begin
        @(negedge clk);
      end
      g++;
    end
    check("wrap_pushed", pushed, 32'd40);
    wait_idle();
    check("wrap_pulses", pulse_cnt, 32'd45);
    check("wrap_no_overflow", 32'(overflow), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
